// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-byte UART transmitter (8N1 or 8N2).
// A write accepted in IDLE latches the byte, then the frame is shifted out
// as start bit, eight data bits LSB first, and STOP_BITS stop bits, each bit
// held for CLK_DIV clock cycles. Writes that arrive mid-frame are dropped and
// flagged with a one-cycle write_drop pulse.
module uart_byte_tx #(
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] write_data,
    input  logic       write_en,
    output logic       tx_busy,
    output logic       uart_tx,
    output logic       tx_done,
    output logic       write_drop
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_baudCnt;
    logic [2:0]       r_bitIdx;
    logic             r_stopIdx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_done;
    logic             r_drop;
    logic             w_bitEnd;
    logic             w_accept;
    logic             w_busy;

    assign w_bitEnd = (r_baudCnt == CNT_LAST);

    // State register: reset aborts any frame and returns straight to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: each non-idle state advances on a bit boundary.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (write_en) w_nextState = START;
            START:   if (w_bitEnd) w_nextState = DATA;
            DATA:    if (w_bitEnd && (r_bitIdx == 3'd7)) w_nextState = STOP;
            STOP:    if (w_bitEnd && (r_stopIdx == LAST_STOP)) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode: busy is any non-idle state, a write is taken only in IDLE.
    always_comb begin
        w_busy   = (r_state != IDLE);
        w_accept = (r_state == IDLE) && write_en;
    end

    // Datapath: baud counter, bit/stop indices, shift register and the
    // registered serial line plus the one-cycle done/drop pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baudCnt <= '0;
            r_bitIdx  <= 3'd0;
            r_stopIdx <= 1'b0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= write_en && w_busy;
            if (r_state == IDLE) begin
                r_baudCnt <= '0;
            end else if (w_bitEnd) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= write_data;
                        r_tx      <= 1'b0;
                        r_bitIdx  <= 3'd0;
                        r_stopIdx <= 1'b0;
                    end
                end
                START: begin
                    if (w_bitEnd) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_bitIdx <= r_bitIdx + 3'd1;
                        if (r_bitIdx == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        if (r_stopIdx == LAST_STOP) begin
                            r_stopIdx <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_stopIdx <= r_stopIdx + 1'b1;
                        end
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign tx_busy    = w_busy;
    assign uart_tx    = r_tx;
    assign tx_done    = r_done;
    assign write_drop = r_drop;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: drives one shared stimulus into a 1-stop-bit and a
// 2-stop-bit transmitter and compares every cycle of both against a
// frame-level reference model and a mid-bit sampling UART receiver.
module tb_uart_byte_tx;

    localparam int CLK_DIV = 4;
    localparam int MAXC    = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] write_data = 8'h00;
    logic       write_en = 1'b0;

    logic tx_busy1, uart_tx1, tx_done1, write_drop1;
    logic tx_busy2, uart_tx2, tx_done2, write_drop2;

    uart_byte_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .write_data (write_data),
        .write_en   (write_en),
        .tx_busy    (tx_busy1),
        .uart_tx    (uart_tx1),
        .tx_done    (tx_done1),
        .write_drop (write_drop1)
    );

    uart_byte_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .write_data (write_data),
        .write_en   (write_en),
        .tx_busy    (tx_busy2),
        .uart_tx    (uart_tx2),
        .tx_done    (tx_done2),
        .write_drop (write_drop2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         wrCyc[$];
    logic [7:0] wrDat[$];
    int         rstAt  = -1;
    int         rstLen = 0;
    int         runLen = 0;

    logic logTx   [2][MAXC];
    logic logBusy [2][MAXC];
    logic logDone [2][MAXC];
    logic logDrop [2][MAXC];

    logic expTx   [MAXC];
    logic expBusy [MAXC];
    logic expDone [MAXC];
    logic expDrop [MAXC];

    logic [7:0] expBytes[$];
    logic [7:0] decBytes[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two cycles; the scenario runner releases it at cycle 0.
    task automatic applyReset;
        reset    = 1'b1;
        write_en = 1'b0;
        repeat (2) tick;
    endtask

    // Drives the write/reset schedule cycle by cycle and logs both DUTs.
    task automatic runScenario;
        for (int c = 0; c < runLen; c++) begin
            reset      = (rstLen > 0) && (c >= rstAt) && (c < rstAt + rstLen);
            write_en   = 1'b0;
            write_data = 8'($urandom);
            foreach (wrCyc[i]) begin
                if (wrCyc[i] == c) begin
                    write_en   = 1'b1;
                    write_data = wrDat[i];
                end
            end
            #1;
            logTx[0][c]   = uart_tx1;
            logBusy[0][c] = tx_busy1;
            logDone[0][c] = tx_done1;
            logDrop[0][c] = write_drop1;
            logTx[1][c]   = uart_tx2;
            logBusy[1][c] = tx_busy2;
            logDone[1][c] = tx_done2;
            logDrop[1][c] = write_drop2;
            tick;
        end
        write_en = 1'b0;
        reset    = 1'b0;
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Reference model: a frame accepted at cycle A occupies A+1..A+(9+S)*CLK_DIV
    // with bit k/CLK_DIV of {start, data LSB first, stops}; done follows at E+1.
    // A write while a frame occupies the line is dropped and flagged next cycle.
    task automatic buildExpected(input int stopBits);
        int busyEnd;
        int a;
        int e;
        int last;
        bit aborted;
        expBytes.delete();
        for (int c = 0; c < MAXC; c++) begin
            expTx[c]   = 1'b1;
            expBusy[c] = 1'b0;
            expDone[c] = 1'b0;
            expDrop[c] = 1'b0;
        end
        busyEnd = -1;
        foreach (wrCyc[i]) begin
            a = wrCyc[i];
            if ((rstLen > 0) && (a >= rstAt) && (a < rstAt + rstLen)) continue;
            if (a <= busyEnd) begin
                expDrop[a+1] = 1'b1;
                continue;
            end
            e       = a + (9 + stopBits) * CLK_DIV;
            aborted = (rstLen > 0) && (rstAt > a) && (rstAt <= e + 1);
            last    = (aborted && (rstAt - 1 < e)) ? rstAt - 1 : e;
            for (int k = 1; a + k <= last; k++) begin
                expTx[a+k]   = frameBit(wrDat[i], (k - 1) / CLK_DIV);
                expBusy[a+k] = 1'b1;
            end
            busyEnd = last;
            if (!aborted) begin
                expDone[e+1] = 1'b1;
                expBytes.push_back(wrDat[i]);
            end
        end
        if (rstLen > 0) begin
            for (int c = rstAt; c < rstAt + rstLen; c++) begin
                expTx[c]   = 1'b1;
                expBusy[c] = 1'b0;
                expDone[c] = 1'b0;
                expDrop[c] = 1'b0;
            end
        end
    endtask

    // Receiver model: finds each falling edge and samples every bit mid-period.
    task automatic decodeLine(input int s, input int fromCyc);
        int c;
        logic [7:0] b;
        decBytes.delete();
        c = fromCyc + 1;
        while (c + 9 * CLK_DIV + CLK_DIV / 2 < runLen) begin
            if (logTx[s][c-1] === 1'b1 && logTx[s][c] === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    b[i] = logTx[s][c + (i + 1) * CLK_DIV + CLK_DIV / 2];
                end
                if (logTx[s][c + 9 * CLK_DIV + CLK_DIV / 2] === 1'b1) begin
                    decBytes.push_back(b);
                end
                c = c + 10 * CLK_DIV;
            end else begin
                c++;
            end
        end
    endtask

    task automatic test_reset;
        applyReset;
        checks++;
        if ({uart_tx1, tx_busy1, tx_done1, write_drop1} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state stop=1 {tx,busy,done,drop} got %b expected 1000",
                     {uart_tx1, tx_busy1, tx_done1, write_drop1});
        end
        checks++;
        if ({uart_tx2, tx_busy2, tx_done2, write_drop2} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state stop=2 {tx,busy,done,drop} got %b expected 1000",
                     {uart_tx2, tx_busy2, tx_done2, write_drop2});
        end
    endtask

    task automatic test_single_byte;
        applyReset;
        wrCyc = {0};
        wrDat = {8'h55};
        rstAt = -1; rstLen = 0; runLen = 60;
        runScenario;
        for (int s = 0; s < 2; s++) begin
            buildExpected(s + 1);
            for (int c = 0; c < runLen; c++) begin
                checks++;
                if ({logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]} !==
                    {expTx[c], expBusy[c], expDone[c], expDrop[c]}) begin
                    errors++;
                    $display("FAIL single_byte stop=%0d cycle %0d {tx,busy,done,drop} got %b expected %b",
                             s + 1, c, {logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]},
                             {expTx[c], expBusy[c], expDone[c], expDrop[c]});
                end
            end
        end
        checks++;
        if ({logBusy[0][40], logBusy[0][41], logDone[0][41]} !== 3'b101) begin
            errors++;
            $display("FAIL single_byte_edge {busy40,busy41,done41} got %b expected 101",
                     {logBusy[0][40], logBusy[0][41], logDone[0][41]});
        end
    endtask

    task automatic test_back_to_back;
        applyReset;
        wrCyc = {0, 41};
        wrDat = {8'hA3, 8'h0D};
        rstAt = -1; rstLen = 0; runLen = 100;
        runScenario;
        for (int s = 0; s < 2; s++) begin
            buildExpected(s + 1);
            for (int c = 0; c < runLen; c++) begin
                checks++;
                if ({logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]} !==
                    {expTx[c], expBusy[c], expDone[c], expDrop[c]}) begin
                    errors++;
                    $display("FAIL back_to_back stop=%0d cycle %0d {tx,busy,done,drop} got %b expected %b",
                             s + 1, c, {logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]},
                             {expTx[c], expBusy[c], expDone[c], expDrop[c]});
                end
            end
        end
        decodeLine(0, 0);
        checks++;
        if (decBytes.size() != 2 || decBytes[0] !== 8'hA3 || decBytes[1] !== 8'h0D) begin
            errors++;
            $display("FAIL back_to_back_decode got %0d bytes (%h %h) expected 2 bytes (a3 0d)",
                     decBytes.size(), (decBytes.size() > 0) ? decBytes[0] : 8'hxx,
                     (decBytes.size() > 1) ? decBytes[1] : 8'hxx);
        end
        checks++;
        if ({logTx[0][41], logTx[0][42]} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_back_gap {tx41,tx42} got %b expected 10", {logTx[0][41], logTx[0][42]});
        end
    endtask

    task automatic test_write_while_busy;
        applyReset;
        wrCyc = {0, 10};
        wrDat = {8'h55, 8'hFF};
        rstAt = -1; rstLen = 0; runLen = 60;
        runScenario;
        for (int s = 0; s < 2; s++) begin
            buildExpected(s + 1);
            for (int c = 0; c < runLen; c++) begin
                checks++;
                if ({logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]} !==
                    {expTx[c], expBusy[c], expDone[c], expDrop[c]}) begin
                    errors++;
                    $display("FAIL write_while_busy stop=%0d cycle %0d {tx,busy,done,drop} got %b expected %b",
                             s + 1, c, {logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]},
                             {expTx[c], expBusy[c], expDone[c], expDrop[c]});
                end
            end
        end
        checks++;
        if ({logDrop[0][10], logDrop[0][11], logDrop[0][12]} !== 3'b010) begin
            errors++;
            $display("FAIL write_drop_pulse {drop10,drop11,drop12} got %b expected 010",
                     {logDrop[0][10], logDrop[0][11], logDrop[0][12]});
        end
    endtask

    task automatic test_reset_mid_frame;
        applyReset;
        wrCyc = {0, 20};
        wrDat = {8'($urandom), 8'h0A};
        rstAt = 17; rstLen = 3; runLen = 80;
        runScenario;
        for (int s = 0; s < 2; s++) begin
            buildExpected(s + 1);
            for (int c = 0; c < runLen; c++) begin
                checks++;
                if ({logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]} !==
                    {expTx[c], expBusy[c], expDone[c], expDrop[c]}) begin
                    errors++;
                    $display("FAIL reset_mid_frame stop=%0d cycle %0d {tx,busy,done,drop} got %b expected %b",
                             s + 1, c, {logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]},
                             {expTx[c], expBusy[c], expDone[c], expDrop[c]});
                end
            end
            decodeLine(s, rstAt + rstLen - 1);
            checks++;
            if (decBytes.size() != 1 || decBytes[0] !== 8'h0A) begin
                errors++;
                $display("FAIL reset_mid_frame_decode stop=%0d got %0d bytes (first %h) expected 1 byte (0a)",
                         s + 1, decBytes.size(), (decBytes.size() > 0) ? decBytes[0] : 8'hxx);
            end
        end
    endtask

    task automatic test_two_stop;
        int busyCount;
        applyReset;
        wrCyc = {0};
        wrDat = {8'h00};
        rstAt = -1; rstLen = 0; runLen = 60;
        runScenario;
        buildExpected(2);
        for (int c = 0; c < runLen; c++) begin
            checks++;
            if ({logTx[1][c], logBusy[1][c], logDone[1][c], logDrop[1][c]} !==
                {expTx[c], expBusy[c], expDone[c], expDrop[c]}) begin
                errors++;
                $display("FAIL two_stop cycle %0d {tx,busy,done,drop} got %b expected %b",
                         c, {logTx[1][c], logBusy[1][c], logDone[1][c], logDrop[1][c]},
                         {expTx[c], expBusy[c], expDone[c], expDrop[c]});
            end
        end
        busyCount = 0;
        for (int c = 0; c < runLen; c++) begin
            if (logBusy[1][c] === 1'b1) busyCount++;
        end
        checks++;
        if (busyCount != 44) begin
            errors++;
            $display("FAIL two_stop_busy_len got %0d cycles expected 44", busyCount);
        end
    endtask

    task automatic test_packet_burst;
        int drops;
        applyReset;
        wrCyc.delete();
        wrDat = {8'hFF, 8'hFF, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'h0D, 8'h0A};
        for (int i = 0; i < 10; i++) wrCyc.push_back(41 * i);
        rstAt = -1; rstLen = 0; runLen = 430;
        runScenario;
        for (int s = 0; s < 2; s++) begin
            buildExpected(s + 1);
            for (int c = 0; c < runLen; c++) begin
                checks++;
                if ({logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]} !==
                    {expTx[c], expBusy[c], expDone[c], expDrop[c]}) begin
                    errors++;
                    $display("FAIL packet_burst stop=%0d cycle %0d {tx,busy,done,drop} got %b expected %b",
                             s + 1, c, {logTx[s][c], logBusy[s][c], logDone[s][c], logDrop[s][c]},
                             {expTx[c], expBusy[c], expDone[c], expDrop[c]});
                end
            end
        end
        decodeLine(0, 0);
        checks++;
        if (decBytes.size() != 10) begin
            errors++;
            $display("FAIL packet_burst_count got %0d bytes expected 10", decBytes.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (decBytes[i] !== wrDat[i]) begin
                    errors++;
                    $display("FAIL packet_burst_byte%0d got %h expected %h", i, decBytes[i], wrDat[i]);
                end
            end
        end
        drops = 0;
        for (int c = 0; c < runLen; c++) begin
            if (logDrop[0][c] !== 1'b0) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL packet_burst_no_drop got %0d drop cycles expected 0", drops);
        end
    endtask

    task automatic test_random;
        int c;
        applyReset;
        wrCyc.delete();
        wrDat.delete();
        c = 0;
        while (c < 520) begin
            wrCyc.push_back(c);
            wrDat.push_back(8'($urandom));
            c = c + int'($urandom_range(1, 50));
        end
        rstAt = -1; rstLen = 0; runLen = 600;
        runScenario;
        for (int s = 0; s < 2; s++) begin
            buildExpected(s + 1);
            for (int k = 0; k < runLen; k++) begin
                checks++;
                if ({logTx[s][k], logBusy[s][k], logDone[s][k], logDrop[s][k]} !==
                    {expTx[k], expBusy[k], expDone[k], expDrop[k]}) begin
                    errors++;
                    $display("FAIL random stop=%0d cycle %0d {tx,busy,done,drop} got %b expected %b",
                             s + 1, k, {logTx[s][k], logBusy[s][k], logDone[s][k], logDrop[s][k]},
                             {expTx[k], expBusy[k], expDone[k], expDrop[k]});
                end
            end
            decodeLine(s, 0);
            checks++;
            if (decBytes != expBytes) begin
                errors++;
                $display("FAIL random_decode stop=%0d got %0d bytes expected %0d bytes (or contents differ)",
                         s + 1, decBytes.size(), expBytes.size());
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_write_while_busy;
        test_reset_mid_frame;
        test_two_stop;
        test_packet_burst;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
